posit_vector_engine: RTL and testbench
======================================

POSIT_VECTOR_ENGINE -- requirements
Module: posit_vector_engine

Interface
REQ-001 Parameter NBITS, default 32, posit width; SHALL be a multiple of 8, giving B = NBITS/8 bytes per element.
REQ-002 Parameter ADDR_W, default 12, byte address width of the on-chip memory port.
REQ-003 Ports, in order:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- io_start  in  ADDR_W-independent 1-bit level from PIO; a run begins on its 0->1 edge.
- io_op  in  2  operation: 00 add, 01 sub, 10 mul, 11 reserved.
- io_src_a_address, io_src_b_address, io_dst_address  in  ADDR_W  vector base byte addresses.
- io_length  in  8  element count.
- io_address_to_access  out  ADDR_W  memory byte address.
- io_read_data  in  8  memory read byte, valid one cycle after its address.
- io_write_data  out  8  memory write byte.
- io_write_enable  out  1  memory write strobe.
- io_busy, io_completed, io_error  out  1  status.
- io_unit_valid  out  1  operand handshake valid, to the posit arithmetic unit.
- io_unit_ready  in  1  operand handshake ready, from the posit arithmetic unit.
- io_unit_op  out  2  operation, copy of the latched io_op.
- io_unit_a, io_unit_b  out  NBITS  operands.
- io_unit_result_valid  in  1  result strobe.
- io_unit_result  in  NBITS  result.

Function
REQ-004 IDLE: on a start edge (start=1, registered start=0), latch op, the three addresses and length; go to READ_A, or to DONE if length=0 or op=11.
REQ-005 Elements are little-endian in memory; element i of a vector occupies base+i*B .. base+i*B+B-1, with the address computed modulo 2^ADDR_W (wrap-around is legal).
REQ-006 READ_A, READ_B: each lasts B+1 cycles; byte k's address is driven in cycle k, and its data is captured in cycle k+1.
REQ-007 ISSUE: drive io_unit_valid=1 with a, b and op held stable until io_unit_ready=1; the transfer completes in the cycle where valid and ready are both 1; then go to WAIT_RES.
REQ-008 WAIT_RES: capture io_unit_result in the first cycle io_unit_result_valid=1; io_unit_result_valid is ignored in every other state.
REQ-009 WRITE: B cycles; io_write_enable=1, with byte k at dst+i*B+k in cycle k.
REQ-010 After the last write byte: if i=length-1, go to DONE; otherwise increment i and go to READ_A.
REQ-011 Per-element latency with ready already high and the result one cycle after handshake: 3B+4 cycles (16 at NBITS=32).
REQ-012 DONE: io_completed=1, held until io_start=0, then go to IDLE; a new run requires a fresh edge.
REQ-013 op=11: set io_error=1 and io_completed=1, with zero memory writes; io_error clears on the next accepted start.
REQ-014 io_busy=1 in every state except IDLE and DONE.
REQ-015 io_write_enable SHALL be 0 outside WRITE.
REQ-016 io_unit_valid SHALL be 0 outside ISSUE.
REQ-017 Start edges seen while busy are ignored.

Reset
REQ-018 reset SHALL force: state IDLE, element index 0, and the registered start to 1, so a start held high through reset does not trigger a run.
REQ-019 reset SHALL set every output to 0: address, write data, write enable, busy, completed, error, unit_valid, unit_op, unit_a, unit_b.
REQ-020 Reset mid-operation SHALL abort within one cycle; io_write_enable is 0 in the cycle after reset is sampled, and partial results stay in memory.

Structure
REQ-021 A shared package SHALL hold the state enumeration, the op encoding constants (ADD, SUB, MUL, RSVD) and the function computing B from NBITS.
REQ-022 One sub-module SHALL be natural: posit_byte_shifter, which assembles and serialises NBITS words from and to bytes; the arithmetic unit stays external.

Verification (NBITS=32, behavioural unit model with result one cycle after handshake)
REQ-023 Single add:
- Memory: A@0x000 = 00 00 00 40 (1.0), B@0x004 = 00 00 00 40, dst = 0x010, length = 1.
- Start at cycle 0; required: bytes 00 00 00 48 (2.0) at 0x010..0x013, and io_completed rising at cycle 17.
REQ-024 length=4 mul with io_unit_ready held low 5 cycles per element:
- Operands and request stay stable while waiting.
- All four results are correct.
- Total latency is 4*(16+5)+1 cycles.
REQ-025 Wrap: src_a=0xFFE, length=1; required: reads at 0xFFE, 0xFFF, 0x000, 0x001.
REQ-026 Boundaries:
- length=0: io_completed=1 two cycles after the edge, with no memory writes.
- op=11: io_error=1 and io_completed=1, with no memory writes.
REQ-027 reset asserted during the WRITE byte 2 cycle:
- io_write_enable is 0 next cycle, and all outputs are 0.
- io_start held high through reset does not trigger a run.
- A later 0->1 edge on io_start runs normally.
REQ-028 io_start held high after completion: io_completed stays 1, with no second run, until io_start=0.

Source files
------------

// File: rtl/posit_vector_engine_pkg.sv
// Shared types for the posit vector engine: controller states, op codes and
// the element byte-count helper.
package posit_vector_engine_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_A,
        S_READ_B,
        S_ISSUE,
        S_WAIT_RES,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    function automatic int bytes_of(input int nbits);
        return nbits / 8;
    endfunction

endpackage

// File: rtl/posit_vector_engine_byte_shifter.sv
// Byte-level view of an NBITS posit word: inserts one little-endian byte into
// a word being assembled, and picks one byte out of a word being serialised.
module posit_byte_shifter
    import posit_vector_engine_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int SEL_W = 3
) (
    input  logic [NBITS-1:0] asm_word,
    input  logic [7:0]       asm_byte,
    input  logic [SEL_W-1:0] asm_sel,
    output logic [NBITS-1:0] asm_out,
    input  logic [NBITS-1:0] ser_word,
    input  logic [SEL_W-1:0] ser_sel,
    output logic [7:0]       ser_byte
);
    localparam int BYTES = bytes_of(NBITS);

    always_comb begin
        asm_out = asm_word;
        for (int k = 0; k < BYTES; k++) begin
            if (asm_sel == SEL_W'(k)) asm_out[k*8 +: 8] = asm_byte;
        end
    end

    always_comb begin
        ser_byte = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (ser_sel == SEL_W'(k)) ser_byte = ser_word[k*8 +: 8];
        end
    end

endmodule

// File: rtl/posit_vector_engine.sv
// Element-wise posit vector controller: streams operands byte-wise from memory,
// hands them to an external posit unit, and writes results back byte-wise.
module posit_vector_engine
    import posit_vector_engine_pkg::*;
#(
    parameter int NBITS  = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_start,
    input  logic [1:0]        io_op,
    input  logic [ADDR_W-1:0] io_src_a_address,
    input  logic [ADDR_W-1:0] io_src_b_address,
    input  logic [ADDR_W-1:0] io_dst_address,
    input  logic [7:0]        io_length,
    output logic [ADDR_W-1:0] io_address_to_access,
    input  logic [7:0]        io_read_data,
    output logic [7:0]        io_write_data,
    output logic              io_write_enable,
    output logic              io_busy,
    output logic              io_completed,
    output logic              io_error,
    output logic              io_unit_valid,
    input  logic              io_unit_ready,
    output logic [1:0]        io_unit_op,
    output logic [NBITS-1:0]  io_unit_a,
    output logic [NBITS-1:0]  io_unit_b,
    input  logic              io_unit_result_valid,
    input  logic [NBITS-1:0]  io_unit_result
);
    localparam int BYTES = bytes_of(NBITS);
    localparam int CNT_W = $clog2(BYTES + 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        idx, len;
    logic              start_q, error_r;
    logic [1:0]        op_r;
    logic [ADDR_W-1:0] src_a, src_b, dst, elem_off;
    logic [NBITS-1:0]  a_r, b_r, res_r, asm_out;
    logic [7:0]        ser_byte;
    logic              start_edge, read_last, write_last, elem_last;

    assign start_edge = io_start && !start_q;
    assign read_last  = (cnt == CNT_W'(BYTES));
    assign write_last = (cnt == CNT_W'(BYTES - 1));
    assign elem_last  = (idx == len - 8'd1);
    // Element offset wraps with the address width; wrap-around is legal.
    assign elem_off   = ADDR_W'(32'(idx) * BYTES);

    posit_byte_shifter #(.NBITS(NBITS), .SEL_W(CNT_W)) u_shifter (
        .asm_word ((state == S_READ_B) ? b_r : a_r),
        .asm_byte (io_read_data),
        .asm_sel  (cnt - CNT_W'(1)),
        .asm_out  (asm_out),
        .ser_word (res_r),
        .ser_sel  (cnt),
        .ser_byte (ser_byte)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (start_edge) state_next = (io_length == 8'd0 || io_op == OP_RSVD)
                                                     ? S_DONE : S_READ_A;
            S_READ_A:   if (read_last) state_next = S_READ_B;
            S_READ_B:   if (read_last) state_next = S_ISSUE;
            S_ISSUE:    if (io_unit_ready) state_next = S_WAIT_RES;
            S_WAIT_RES: if (io_unit_result_valid) state_next = S_WRITE;
            S_WRITE:    if (write_last) state_next = elem_last ? S_DONE : S_READ_A;
            S_DONE:     if (!io_start) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Registered start resets high so a start held through reset is not an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            idx     <= '0;
            start_q <= 1'b1;
            error_r <= 1'b0;
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
        end else begin
            start_q <= io_start;
            if (state_next != state) cnt <= '0;
            else if (state inside {S_READ_A, S_READ_B, S_WRITE}) cnt <= cnt + CNT_W'(1);
            if (state == S_IDLE && start_edge) begin
                op_r    <= io_op;
                idx     <= '0;
                error_r <= (io_op == OP_RSVD);
            end
            if (state == S_READ_A && cnt != '0) a_r <= asm_out;
            if (state == S_READ_B && cnt != '0) b_r <= asm_out;
            if (state == S_WRITE && write_last && !elem_last) idx <= idx + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (state == S_IDLE && start_edge) begin
            src_a <= io_src_a_address;
            src_b <= io_src_b_address;
            dst   <= io_dst_address;
            len   <= io_length;
        end
        if (state == S_WAIT_RES && io_unit_result_valid) res_r <= io_unit_result;
    end

    // The capture-only last read cycle drives no address.
    always_comb begin
        io_address_to_access = '0;
        io_write_data        = '0;
        io_write_enable      = 1'b0;
        io_busy              = 1'b1;
        io_completed         = 1'b0;
        io_unit_valid        = 1'b0;
        case (state)
            S_IDLE:   io_busy = 1'b0;
            S_READ_A: if (!read_last) io_address_to_access = src_a + elem_off + ADDR_W'(cnt);
            S_READ_B: if (!read_last) io_address_to_access = src_b + elem_off + ADDR_W'(cnt);
            S_ISSUE:  io_unit_valid = 1'b1;
            S_WRITE: begin
                io_write_enable      = 1'b1;
                io_write_data        = ser_byte;
                io_address_to_access = dst + elem_off + ADDR_W'(cnt);
            end
            S_DONE: begin
                io_busy      = 1'b0;
                io_completed = 1'b1;
            end
            default: ;
        endcase
    end

    assign io_error   = error_r;
    assign io_unit_op = op_r;
    assign io_unit_a  = a_r;
    assign io_unit_b  = b_r;

endmodule

// File: tb/tb_posit_vector_engine.sv
// Bench for posit_vector_engine: byte memory, stand-in posit32 (es=2) unit and
// a sequential element-wise reference model of the whole vector operation.
module tb_posit_vector_engine;
    import posit_vector_engine_pkg::*;

    localparam int NBITS  = 32;
    localparam int ADDR_W = 12;
    localparam int B      = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_start;
    logic [1:0]        io_op;
    logic [ADDR_W-1:0] io_src_a_address, io_src_b_address, io_dst_address;
    logic [7:0]        io_length;
    logic [ADDR_W-1:0] io_address_to_access;
    logic [7:0]        io_read_data;
    logic [7:0]        io_write_data;
    logic              io_write_enable, io_busy, io_completed, io_error;
    logic              io_unit_valid, io_unit_ready;
    logic [1:0]        io_unit_op;
    logic [NBITS-1:0]  io_unit_a, io_unit_b;
    logic              io_unit_result_valid;
    logic [NBITS-1:0]  io_unit_result;

    posit_vector_engine #(.NBITS(NBITS), .ADDR_W(ADDR_W)) dut (
        .clock                (clock),
        .reset                (reset),
        .io_start             (io_start),
        .io_op                (io_op),
        .io_src_a_address     (io_src_a_address),
        .io_src_b_address     (io_src_b_address),
        .io_dst_address       (io_dst_address),
        .io_length            (io_length),
        .io_address_to_access (io_address_to_access),
        .io_read_data         (io_read_data),
        .io_write_data        (io_write_data),
        .io_write_enable      (io_write_enable),
        .io_busy              (io_busy),
        .io_completed         (io_completed),
        .io_error             (io_error),
        .io_unit_valid        (io_unit_valid),
        .io_unit_ready        (io_unit_ready),
        .io_unit_op           (io_unit_op),
        .io_unit_a            (io_unit_a),
        .io_unit_b            (io_unit_b),
        .io_unit_result_valid (io_unit_result_valid),
        .io_unit_result       (io_unit_result)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- posit32, es=2, via real arithmetic ----------------
    function automatic real p_dec(input logic [31:0] p);
        logic [31:0] v;
        int pos, k, e;
        real f, w, r;
        if (p == 32'd0) return 0.0;
        v = p[31] ? (~p + 32'd1) : p;
        pos = 30;
        if (v[30]) begin
            k = -1;
            while (pos >= 0 && v[pos]) begin k++; pos--; end
        end else begin
            k = 0;
            while (pos >= 0 && !v[pos]) begin k--; pos--; end
        end
        pos--;
        e = 0;
        for (int j = 0; j < 2; j++) begin
            e = e * 2 + ((pos >= 0 && v[pos]) ? 1 : 0);
            pos--;
        end
        f = 1.0;
        w = 0.5;
        while (pos >= 0) begin
            if (v[pos]) f = f + w;
            w = w / 2.0;
            pos--;
        end
        r = f;
        for (int j = 0; j < 4 * k + e; j++) r = r * 2.0;
        for (int j = 0; j > 4 * k + e; j--) r = r / 2.0;
        return p[31] ? -r : r;
    endfunction

    function automatic logic [31:0] p_enc(input real x);
        logic [63:0] bits;
        logic [31:0] r;
        int pos, s, k, e;
        real m;
        bit neg;
        if (x == 0.0) return 32'd0;
        neg = (x < 0.0);
        m = neg ? -x : x;
        s = 0;
        while (m >= 2.0) begin m = m / 2.0; s++; end
        while (m < 1.0) begin m = m * 2.0; s--; end
        k = (s >= 0) ? s / 4 : -((-s + 3) / 4);
        e = s - 4 * k;
        bits = '0;
        pos = 62;
        if (k >= 0) begin
            for (int i = 0; i <= k; i++) begin if (pos >= 0) bits[pos] = 1'b1; pos--; end
            pos--;
        end else begin
            for (int i = 0; i < -k; i++) pos--;
            if (pos >= 0) bits[pos] = 1'b1;
            pos--;
        end
        if (pos >= 0) bits[pos] = e[1];
        pos--;
        if (pos >= 0) bits[pos] = e[0];
        pos--;
        m = m - 1.0;
        while (pos >= 0) begin
            m = m * 2.0;
            if (m >= 1.0) begin bits[pos] = 1'b1; m = m - 1.0; end
            pos--;
        end
        r = bits[63:32];
        return neg ? (~r + 32'd1) : r;
    endfunction

    function automatic logic [31:0] posit_calc(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        real ra, rb;
        ra = p_dec(a);
        rb = p_dec(b);
        case (op)
            OP_ADD:  return p_enc(ra + rb);
            OP_SUB:  return p_enc(ra - rb);
            OP_MUL:  return p_enc(ra * rb);
            default: return 32'h8000_0000;
        endcase
    endfunction

    // ---------------- memory and unit stand-ins ----------------
    logic [7:0] mem     [4096];
    logic [7:0] ref_mem [4096];
    logic       load_req;

    always @(posedge clock) begin
        if (load_req) begin
            for (int i = 0; i < 4096; i++) mem[i] <= ref_mem[i];
        end else begin
            io_read_data <= mem[io_address_to_access];
            if (io_write_enable) mem[io_address_to_access] <= io_write_data;
        end
    end

    int stall_cfg;
    int wait_cnt;
    assign io_unit_ready = (wait_cnt >= stall_cfg);

    always @(posedge clock) begin
        if (reset) begin
            wait_cnt             <= 0;
            io_unit_result_valid <= 1'b0;
            io_unit_result       <= '0;
        end else if (io_unit_valid && io_unit_ready) begin
            wait_cnt             <= 0;
            io_unit_result_valid <= 1'b1;
            io_unit_result       <= posit_calc(io_unit_op, io_unit_a, io_unit_b);
        end else begin
            io_unit_result_valid <= 1'b0;
            if (io_unit_valid) wait_cnt <= wait_cnt + 1;
        end
    end

    // ---------------- monitor ----------------
    int          wr_count = 0;
    logic [1:0]  exp_op;
    logic        stall_prev;
    logic [31:0] prev_a, prev_b;
    logic [1:0]  prev_op;

    always @(negedge clock) begin
        if (io_write_enable) wr_count <= wr_count + 1;
        if (!reset && stall_prev) begin
            check_eq("hold_valid", io_unit_valid, 1'b1);
            check_eq("hold_a", io_unit_a, prev_a);
            check_eq("hold_b", io_unit_b, prev_b);
            check_eq("hold_op", io_unit_op, prev_op);
        end
        if (io_unit_valid && io_unit_ready) check_eq("unit_op", io_unit_op, exp_op);
        stall_prev <= !reset && io_unit_valid && !io_unit_ready;
        prev_a     <= io_unit_a;
        prev_b     <= io_unit_b;
        prev_op    <= io_unit_op;
    end

    // ---------------- reference model helpers ----------------
    logic [11:0] rd_addr [$];

    function automatic logic [31:0] ref_word(input logic [11:0] base, input int i);
        logic [31:0] w;
        for (int k = 0; k < B; k++) w[k*8 +: 8] = ref_mem[base + 12'(i * B + k)];
        return w;
    endfunction

    function automatic logic [31:0] mem_word(input logic [11:0] base, input int i);
        logic [31:0] w;
        for (int k = 0; k < B; k++) w[k*8 +: 8] = mem[base + 12'(i * B + k)];
        return w;
    endfunction

    task automatic put_word(input logic [11:0] base, input int i, input logic [31:0] w);
        for (int k = 0; k < B; k++) ref_mem[base + 12'(i * B + k)] = w[k*8 +: 8];
    endtask

    function automatic logic [31:0] rand_posit();
        return p_enc(real'(int'($urandom_range(80)) - 40));
    endfunction

    task automatic load_mem();
        load_req = 1'b1;
        @(negedge clock);
        load_req = 1'b0;
    endtask

    task automatic check_image(input string tag);
        int bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
        check_eq(tag, bad, 0);
    endtask

    task automatic launch(input logic [1:0] op, input logic [11:0] sa, input logic [11:0] sb,
                          input logic [11:0] sd, input logic [7:0] len, output int lat);
        bit done = 1'b0;
        int t0;
        exp_op = op;
        io_op = op;
        io_src_a_address = sa;
        io_src_b_address = sb;
        io_dst_address = sd;
        io_length = len;
        io_start = 1'b1;
        t0 = cyc;
        rd_addr.delete();
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clock);
            if (cyc - t0 <= 4) rd_addr.push_back(io_address_to_access);
            done = io_completed;
        end
        lat = cyc - t0;
        check_eq("run_completes", done, 1'b1);
    endtask

    task automatic end_run();
        io_start = 1'b0;
        @(negedge clock);
        check_eq("completed_clears", io_completed, 1'b0);
    endtask

    task automatic run_vec(input logic [1:0] op, input logic [11:0] sa, input logic [11:0] sb,
                           input logic [11:0] sd, input int len, input int stall,
                           input bit hold, output int lat);
        logic [31:0] expq [$];
        logic [31:0] r;
        int w0;
        stall_cfg = stall;
        for (int i = 0; i < len; i++) begin
            put_word(sa, i, rand_posit());
            put_word(sb, i, rand_posit());
        end
        load_mem();
        for (int i = 0; i < len; i++) begin
            r = posit_calc(op, ref_word(sa, i), ref_word(sb, i));
            put_word(sd, i, r);
            expq.push_back(r);
        end
        w0 = wr_count;
        launch(op, sa, sb, sd, 8'(len), lat);
        check_eq("error_clear", io_error, 1'b0);
        check_eq("busy_done", io_busy, 1'b0);
        for (int i = 0; i < len; i++) check_eq("elem_result", mem_word(sd, i), expq[i]);
        check_eq("write_count", wr_count - w0, len * B);
        check_image("mem_image");
        if (hold) begin
            repeat (8) @(negedge clock);
            check_eq("hold_completed", io_completed, 1'b1);
            check_eq("hold_no_rerun", wr_count - w0, len * B);
        end
        end_run();
        stall_cfg = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, w0, n;
        logic [11:0] base;
        logic [31:0] r0;

        reset = 1'b1;
        io_start = 1'b1;
        io_op = 2'b00;
        io_src_a_address = '0;
        io_src_b_address = '0;
        io_dst_address = '0;
        io_length = '0;
        load_req = 1'b0;
        stall_cfg = 0;
        exp_op = 2'b00;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
        @(negedge clock);
        load_mem();
        @(negedge clock);
        check_eq("rst_ctrl", {io_address_to_access, io_write_data, io_write_enable, io_busy,
                              io_completed, io_error, io_unit_valid, io_unit_op}, 0);
        check_eq("rst_operands", {io_unit_a, io_unit_b}, 0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_eq("start_held_thru_reset", {io_busy, io_completed}, 2'b00);
        io_start = 1'b0;
        @(negedge clock);

        // single add 1.0 + 1.0
        put_word(12'h000, 0, 32'h4000_0000);
        put_word(12'h004, 0, 32'h4000_0000);
        load_mem();
        put_word(12'h010, 0, 32'h4800_0000);
        w0 = wr_count;
        launch(OP_ADD, 12'h000, 12'h004, 12'h010, 8'd1, lat);
        check_eq("add_latency", lat, 17);
        check_eq("add_result", mem_word(12'h010, 0), 32'h4800_0000);
        check_eq("add_writes", wr_count - w0, 4);
        check_image("add_image");
        end_run();

        // four-element multiply with a stalled unit
        run_vec(OP_MUL, 12'h040, 12'h080, 12'h0C0, 4, 5, 1'b0, lat);
        check_eq("mul4_latency", lat, 4 * (16 + 5) + 1);

        // source wrapping past the top of the address space
        run_vec(OP_SUB, 12'hFFE, 12'h100, 12'h200, 1, 0, 1'b0, lat);
        check_eq("wrap_reads", rd_addr.size(), 4);
        for (int k = 0; k < 4 && k < rd_addr.size(); k++) begin
            base = 12'hFFE + 12'(k);
            check_eq("wrap_addr", rd_addr[k], base);
        end

        // zero length
        w0 = wr_count;
        launch(OP_ADD, 12'h300, 12'h340, 12'h380, 8'd0, lat);
        check_eq("len0_fast", (lat <= 2), 1'b1);
        check_eq("len0_writes", wr_count - w0, 0);
        end_run();

        // reserved op
        w0 = wr_count;
        launch(OP_RSVD, 12'h300, 12'h340, 12'h380, 8'd3, lat);
        check_eq("rsvd_error", io_error, 1'b1);
        check_eq("rsvd_writes", wr_count - w0, 0);
        check_image("rsvd_image");
        end_run();

        // start held high after completion, then randomized runs
        run_vec(OP_ADD, 12'h500, 12'h900, 12'hD00, 3, 1, 1'b1, lat);
        for (int t = 0; t < 6; t++) begin
            base = 12'($urandom);
            run_vec(2'($urandom_range(2)), base, base + 12'h400, base + 12'h800,
                    int'($urandom_range(1, 6)), int'($urandom_range(3)), 1'b0, lat);
        end

        // reset during write byte 2 of the first element
        stall_cfg = 0;
        put_word(12'h600, 0, rand_posit());
        put_word(12'h640, 0, rand_posit());
        put_word(12'h600, 1, rand_posit());
        put_word(12'h640, 1, rand_posit());
        load_mem();
        r0 = posit_calc(OP_ADD, ref_word(12'h600, 0), ref_word(12'h640, 0));
        w0 = wr_count;
        exp_op = OP_ADD;
        io_op = OP_ADD;
        io_src_a_address = 12'h600;
        io_src_b_address = 12'h640;
        io_dst_address = 12'h680;
        io_length = 8'd2;
        io_start = 1'b1;
        n = 0;
        while (!io_write_enable && n < 100) begin @(negedge clock); n++; end
        check_eq("reach_write", io_write_enable, 1'b1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_eq("abort_ctrl", {io_address_to_access, io_write_data, io_write_enable, io_busy,
                                io_completed, io_error, io_unit_valid, io_unit_op}, 0);
        check_eq("abort_operands", {io_unit_a, io_unit_b}, 0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_eq("no_run_after_abort", {io_busy, io_completed}, 2'b00);
        for (int k = 0; k < 3; k++) ref_mem[12'h680 + 12'(k)] = r0[k*8 +: 8];
        check_eq("partial_writes", wr_count - w0, 3);
        check_image("partial_image");
        io_start = 1'b0;
        @(negedge clock);
        run_vec(OP_MUL, 12'h600, 12'h640, 12'h680, 2, 0, 1'b0, lat);
        check_eq("rerun_latency", lat, 2 * 16 + 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
